// File: rtl/sram_fifo_pkg.sv
// Shared types and constants for the SRAM FIFO read-side scheduler.
// The FSM encoding and full-threshold derivation live here so that sibling blocks agree.
package sram_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int DEF_QUEUE_DEPTH = 1024;
  localparam int DEF_BURST_LEN   = 8;
  localparam int FULL_THRESH     = DEF_QUEUE_DEPTH - DEF_BURST_LEN;

  // A queue is full once it can no longer absorb one more maximum-size burst.
  function automatic int full_thresh(input int depth, input int burst);
    return depth - burst;
  endfunction

endpackage

// File: rtl/sram_fifo_rr_pick.sv
// Combinational rotate-priority select: the first eligible queue at or after ptr_i wins.
module sram_fifo_rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   eligible_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [IDW-1:0] winner_o,
  output logic           any_o
);

  // Walk from the farthest offset down so the nearest eligible queue is written last.
  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr_i) + k) % N;
      if (eligible_i[idx]) begin
        winner_o = IDW'(idx);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_fifo_rd_scheduler.sv
// Read-side scheduler: per-queue SRAM occupancy, full/overflow flags, partial-burst aging,
// and round-robin issue of read-burst commands to the SRAM read engine.
module sram_fifo_rd_scheduler
  import sram_fifo_pkg::*;
#(
  parameter int NUM_QUEUES     = 4,
  parameter int QUEUE_ID_WIDTH = 2,
  parameter int QUEUE_DEPTH    = DEF_QUEUE_DEPTH,
  parameter int CNT_WIDTH      = 11,
  parameter int BURST_LEN      = DEF_BURST_LEN,
  parameter int LEN_WIDTH      = 4,
  parameter int FLUSH_TIMEOUT  = 255
) (
  input  logic                            axi_aclk,
  input  logic                            axi_resetn,
  input  logic                            wr_commit,
  input  logic [QUEUE_ID_WIDTH-1:0]       wr_commit_qid,
  input  logic [NUM_QUEUES-1:0]           out_afull,
  output logic                            rd_cmd_valid,
  input  logic                            rd_cmd_ready,
  output logic [QUEUE_ID_WIDTH-1:0]       rd_cmd_qid,
  output logic [LEN_WIDTH-1:0]            rd_cmd_len,
  output logic [NUM_QUEUES-1:0]           mem_queue_full,
  output logic [NUM_QUEUES*CNT_WIDTH-1:0] occupancy,
  output logic [NUM_QUEUES-1:0]           err_overflow
);

  localparam int AGE_W = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(QUEUE_DEPTH);
  localparam logic [CNT_WIDTH-1:0] BURST_C  = CNT_WIDTH'(BURST_LEN);
  localparam logic [CNT_WIDTH-1:0] THRESH_C = CNT_WIDTH'(full_thresh(QUEUE_DEPTH, BURST_LEN));
  localparam logic [AGE_W-1:0]     AGE_MAX  = AGE_W'(FLUSH_TIMEOUT);

  logic [CNT_WIDTH-1:0]      cnt_q [NUM_QUEUES];
  logic [CNT_WIDTH-1:0]      cnt_d [NUM_QUEUES];
  logic [AGE_W-1:0]          age_q [NUM_QUEUES];
  logic [AGE_W-1:0]          age_d [NUM_QUEUES];
  logic [NUM_QUEUES-1:0]     full_q, full_d;
  logic [NUM_QUEUES-1:0]     ovf_q, ovf_d;
  logic [NUM_QUEUES-1:0]     eligible;
  logic [NUM_QUEUES-1:0]     commitHit, cmdTake;

  state_e                    state_q;
  logic                      valid_q;
  logic [QUEUE_ID_WIDTH-1:0] qid_q;
  logic [LEN_WIDTH-1:0]      len_q;
  logic [QUEUE_ID_WIDTH-1:0] ptr_q;

  logic [QUEUE_ID_WIDTH-1:0] winner;
  logic                      anyElig;
  logic [CNT_WIDTH-1:0]      winCnt;
  logic [CNT_WIDTH-1:0]      capLen;
  logic                      accept;

  assign accept = valid_q & rd_cmd_ready;

  // Per-queue bookkeeping; the decrement uses the length captured from the count, so it cannot underflow.
  always_comb begin
    for (int q = 0; q < NUM_QUEUES; q++) begin
      commitHit[q] = wr_commit && (wr_commit_qid == QUEUE_ID_WIDTH'(q));
      cmdTake[q]   = accept && (qid_q == QUEUE_ID_WIDTH'(q));
      cnt_d[q]     = cnt_q[q]
                   + CNT_WIDTH'(commitHit[q] && (cnt_q[q] != DEPTH_C))
                   - (cmdTake[q] ? CNT_WIDTH'(len_q) : '0);
      ovf_d[q]     = ovf_q[q] | (commitHit[q] && (cnt_q[q] == DEPTH_C));
      full_d[q]    = cnt_d[q] > THRESH_C;
      if ((cnt_q[q] == '0) || (cnt_q[q] >= BURST_C) || cmdTake[q]) begin
        age_d[q] = '0;
      end else if (age_q[q] != AGE_MAX) begin
        age_d[q] = age_q[q] + AGE_W'(1);
      end else begin
        age_d[q] = age_q[q];
      end
      eligible[q] = !out_afull[q] &&
                    ((cnt_q[q] >= BURST_C) || ((cnt_q[q] != '0) && (age_q[q] == AGE_MAX)));
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        cnt_q[q] <= '0;
        age_q[q] <= '0;
      end
      full_q <= '0;
      ovf_q  <= '0;
    end else begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        cnt_q[q] <= cnt_d[q];
        age_q[q] <= age_d[q];
      end
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

  sram_fifo_rr_pick #(
    .N   (NUM_QUEUES),
    .IDW (QUEUE_ID_WIDTH)
  ) u_rr_pick (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .winner_o   (winner),
    .any_o      (anyElig)
  );

  assign winCnt = cnt_q[winner];
  assign capLen = (winCnt < BURST_C) ? winCnt : BURST_C;

  // Once latched, a command is held unchanged until accepted regardless of afull or aging.
  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      qid_q   <= '0;
      len_q   <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyElig) begin
            qid_q   <= winner;
            len_q   <= capLen[LEN_WIDTH-1:0];
            valid_q <= 1'b1;
            state_q <= CMD;
          end
        end
        CMD: begin
          if (accept) begin
            valid_q <= 1'b0;
            ptr_q   <= (qid_q == QUEUE_ID_WIDTH'(NUM_QUEUES - 1)) ? '0 : qid_q + QUEUE_ID_WIDTH'(1);
            state_q <= GAP;
          end
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_cmd_valid   = valid_q;
  assign rd_cmd_qid     = qid_q;
  assign rd_cmd_len     = len_q;
  assign mem_queue_full = full_q;
  assign err_overflow   = ovf_q;

  for (genvar g = 0; g < NUM_QUEUES; g++) begin : gen_occ
    assign occupancy[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

endmodule
